// File: rtl/pio_mem_wide.sv
// pio_mem_wide: PIO-accessible 1R1W table whose rows are wider than one PIO word.
// Multi-word PIO writes collect in staging registers and commit to the RAM atomically
// on the last word. A PIO read of word 0 snapshots the whole row, so software sees a
// coherent entry. The application read port shares the RAM read port and always wins it.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif

module pio_mem_wide #(
    parameter int WIDTH       = 72,
    parameter int DEPTH_NBITS = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_div,
    input  logic [`PIO_NBITS-1:0]  reg_addr,
    input  logic [`PIO_NBITS-1:0]  reg_din,
    input  logic                   reg_rd,
    input  logic                   reg_wr,
    input  logic                   reg_ms,
    input  logic                   app_mem_rd,
    input  logic [DEPTH_NBITS-1:0] app_mem_raddr,
    output logic                   wr_active,
    output logic [DEPTH_NBITS-1:0] wr_addr,
    output logic [WIDTH-1:0]       wr_data,
    output logic                   mem_ack,
    output logic [`PIO_NBITS-1:0]  mem_rdata,
    output logic                   app_mem_ack,
    output logic [WIDTH-1:0]       app_mem_rdata
);
    localparam int PW     = `PIO_NBITS;
    localparam int NW     = (WIDTH + PW - 1) / PW;
    localparam int WB     = (NW > 1) ? $clog2(NW) : 1;
    localparam int STG_N  = (NW > 1) ? NW - 1 : 1;
    localparam int LAST_W = WIDTH - (NW - 1) * PW;
    localparam int DEPTH  = 1 << DEPTH_NBITS;
    localparam int ENT_LO = WB + 2;
    localparam int ENT_HI = ENT_LO + DEPTH_NBITS - 1;
    localparam logic [WB-1:0] LAST_WORD = WB'(NW - 1);

    // Address decode: dword index splits into word-within-entry and entry index
    logic [WB-1:0]          wordSel;
    logic [DEPTH_NBITS-1:0] entrySel;
    logic                   pioRd;
    logic                   pioWr;
    logic                   isWord0;
    logic                   unusedAddrBits;

    assign wordSel        = reg_addr[WB+1:2];
    assign entrySel       = reg_addr[ENT_HI:ENT_LO];
    assign pioRd          = reg_rd & reg_ms;
    assign pioWr          = reg_wr & reg_ms;
    assign isWord0        = (wordSel == '0);
    assign unusedAddrBits = ^{reg_addr[PW-1:ENT_HI+1], reg_addr[1:0]};

    // State registers
    logic [STG_N*PW-1:0]    stage_q,    stage_d;
    logic [WIDTH-1:0]       snap_q,     snap_d;
    logic [PW-1:0]          memRdata_q, memRdata_d;
    logic                   done_q,     done_d;
    logic                   nAck_q,     nAck_d;
    logic                   memAck_q,   memAck_d;
    logic                   pend_q,     pend_d;
    logic [DEPTH_NBITS-1:0] pendAddr_q, pendAddr_d;
    logic                   appRdD1_q,  appRdD1_d;
    logic [DEPTH_NBITS-1:0] appRaddr_q, appRaddr_d;
    logic                   appAck_q,   appAck_d;
    logic [WIDTH-1:0]       appRdata_q, appRdata_d;
    logic                   wrActive_q, wrActive_d;
    logic [DEPTH_NBITS-1:0] wrAddr_q,   wrAddr_d;
    logic [WIDTH-1:0]       wrData_q,   wrData_d;

    // Shared single read port: the app owns it whenever its delayed request is live
    logic [WIDTH-1:0]       ram [DEPTH];
    logic [DEPTH_NBITS-1:0] rdAddr;
    logic [WIDTH-1:0]       ramRow;
    logic                   ramWe;
    logic                   serveRd;
    logic [WIDTH-1:0]       commitRow;
    logic [NW*PW-1:0]       snapPad;
    logic [PW-1:0]          snapWord;

    assign rdAddr  = appRdD1_q ? appRaddr_q : (pend_q ? pendAddr_q : entrySel);
    assign ramRow  = ram[rdAddr];
    assign ramWe   = pioWr & (wordSel == LAST_WORD);
    assign serveRd = ~appRdD1_q & (pend_q | (pioRd & isWord0));

    // Row to commit: staged lower words plus the live last word, top pad bits dropped
    always_comb begin
        commitRow = '0;
        for (int k = 0; k < NW - 1; k++) begin
            commitRow[k*PW +: PW] = stage_q[k*PW +: PW];
        end
        commitRow[WIDTH-1 -: LAST_W] = reg_din[LAST_W-1:0];
    end

    // Pick the addressed snapshot word; hole words and pad bits read back as zero
    always_comb begin
        snapPad              = '0;
        snapPad[WIDTH-1:0]   = snap_q;
        snapWord             = '0;
        for (int k = 0; k < NW; k++) begin
            if (wordSel == WB'(k)) snapWord = snapPad[k*PW +: PW];
        end
    end

    // RAM write port; a same-cycle read sees the old row since the write lands at the edge
    always_ff @(posedge clk) begin
        if (ramWe) ram[entrySel] <= commitRow;
    end

    // Next-state for PIO staging, snapshot, arbitration, ack handshake and app pipeline
    always_comb begin
        stage_d    = stage_q;
        snap_d     = snap_q;
        memRdata_d = memRdata_q;
        pend_d     = pend_q;
        pendAddr_d = pendAddr_q;
        wrActive_d = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        done_d     = 1'b0;
        appRdD1_d  = app_mem_rd;
        appRaddr_d = app_mem_raddr;
        appAck_d   = appRdD1_q;
        appRdata_d = appRdD1_q ? ramRow : appRdata_q;
        nAck_d     = done_q ? 1'b1 : (clk_div ? 1'b0 : nAck_q);
        memAck_d   = clk_div ? nAck_q : memAck_q;

        if (pioWr) begin
            done_d = 1'b1;
            for (int k = 0; k < NW - 1; k++) begin
                if (wordSel == WB'(k)) stage_d[k*PW +: PW] = reg_din;
            end
            if (wordSel == LAST_WORD) begin
                wrActive_d = 1'b1;
                wrAddr_d   = entrySel;
                wrData_d   = commitRow;
            end
        end

        if (pioRd) begin
            if (isWord0) begin
                if (appRdD1_q) begin
                    pend_d     = 1'b1;
                    pendAddr_d = entrySel;
                end
            end else begin
                done_d     = 1'b1;
                memRdata_d = snapWord;
            end
        end

        if (serveRd) begin
            pend_d     = 1'b0;
            snap_d     = ramRow;
            memRdata_d = PW'(ramRow);
            done_d     = 1'b1;
        end
    end

    // State register with async active-low reset; a pending read is simply dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q    <= '0;
            snap_q     <= '0;
            memRdata_q <= '0;
            done_q     <= 1'b0;
            nAck_q     <= 1'b0;
            memAck_q   <= 1'b0;
            pend_q     <= 1'b0;
            pendAddr_q <= '0;
            appRdD1_q  <= 1'b0;
            appRaddr_q <= '0;
            appAck_q   <= 1'b0;
            appRdata_q <= '0;
            wrActive_q <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
        end else begin
            stage_q    <= stage_d;
            snap_q     <= snap_d;
            memRdata_q <= memRdata_d;
            done_q     <= done_d;
            nAck_q     <= nAck_d;
            memAck_q   <= memAck_d;
            pend_q     <= pend_d;
            pendAddr_q <= pendAddr_d;
            appRdD1_q  <= appRdD1_d;
            appRaddr_q <= appRaddr_d;
            appAck_q   <= appAck_d;
            appRdata_q <= appRdata_d;
            wrActive_q <= wrActive_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
        end
    end

    assign wr_active     = wrActive_q;
    assign wr_addr       = wrAddr_q;
    assign wr_data       = wrData_q;
    assign mem_ack       = memAck_q;
    assign mem_rdata     = memRdata_q;
    assign app_mem_ack   = appAck_q;
    assign app_mem_rdata = appRdata_q;

endmodule

// File: tb/tb_pio_mem_wide.sv
// tb_pio_mem_wide: scoreboard bench for pio_mem_wide (WIDTH=72, 64 entries, 32-bit PIO).
// A reference table of rows tracks commits; expectations are queued when stimulus
// is issued and a negedge monitor pops them whenever the DUT presents an output.
module tb_pio_mem_wide;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_div;
    logic [31:0] reg_addr;
    logic [31:0] reg_din;
    logic        reg_rd;
    logic        reg_wr;
    logic        reg_ms;
    logic        app_mem_rd;
    logic [5:0]  app_mem_raddr;
    logic        wr_active;
    logic [5:0]  wr_addr;
    logic [71:0] wr_data;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        app_mem_ack;
    logic [71:0] app_mem_rdata;

    pio_mem_wide #(.WIDTH(72), .DEPTH_NBITS(6)) dut (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
        .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_ms(reg_ms),
        .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
        .wr_active(wr_active), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference state following the row/word layout of the table
    logic [71:0] refMem [64];
    logic [31:0] stageM [2];
    logic [71:0] snapM;
    logic [31:0] curRdata;
    logic        prevAppRd;
    int          prevAppAddr;
    bit          appRandom;

    logic [71:0] appQ [$];
    logic [31:0] pioQ [$];
    logic [77:0] wrQ  [$];

    int tests = 0;
    int fails = 0;
    bit memAckPrev = 1'b0;

    // PIO-domain strobe: one clk wide every fourth clk
    initial begin
        int divCnt = 0;
        clk_div = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            divCnt++;
            clk_div = (divCnt % 4 == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [77:0] act, input logic [77:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reportUnexpected(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: got unexpected output expected none", name);
    endtask

    // Monitor: every DUT output event must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_active) begin
                if (wrQ.size() == 0) reportUnexpected("wr_commit");
                else checkOutput("wr_commit", {wr_addr, wr_data}, wrQ.pop_front());
            end
            if (app_mem_ack) begin
                if (appQ.size() == 0) reportUnexpected("app_read");
                else checkOutput("app_read", {6'b0, app_mem_rdata}, {6'b0, appQ.pop_front()});
            end
            if (mem_ack && !memAckPrev) begin
                if (pioQ.size() == 0) reportUnexpected("pio_ack");
                else checkOutput("pio_rdata", {46'b0, mem_rdata}, {46'b0, pioQ.pop_front()});
            end
        end
        memAckPrev = rst_n ? mem_ack : 1'b0;
    end

    task automatic modelWrite(input int entry, input int word, input logic [31:0] din);
        logic [71:0] row;
        if (word < 2) begin
            stageM[word] = din;
        end else if (word == 2) begin
            row = {din[7:0], stageM[1], stageM[0]};
            wrQ.push_back({6'(entry), row});
            refMem[entry] = row;
        end
        pioQ.push_back(curRdata);
    endtask

    task automatic modelRead(input int entry, input int word);
        case (word)
            0: begin snapM = refMem[entry]; curRdata = snapM[31:0]; end
            1: curRdata = snapM[63:32];
            2: curRdata = {24'b0, snapM[71:64]};
            default: curRdata = 32'b0;
        endcase
        pioQ.push_back(curRdata);
    endtask

    // Drive one clk of inputs; an app request's RAM read happens one clk later,
    // so its expectation is captured then, before that clk's commit (read-before-write)
    task automatic applyStimulus(input logic rd, input logic wr, input logic ms, input int entry,
                                 input int word, input logic [31:0] din, input logic aRd, input int aAddr);
        reg_rd        = rd;
        reg_wr        = wr;
        reg_ms        = ms;
        reg_addr      = 32'((entry * 4 + word) * 4) | ($urandom & 32'h3);
        reg_din       = din;
        app_mem_rd    = aRd;
        app_mem_raddr = 6'(aAddr);
        if (prevAppRd) appQ.push_back(refMem[prevAppAddr]);
        if (ms && wr) modelWrite(entry, word, din);
        if (ms && rd) modelRead(entry, word);
        prevAppRd   = aRd;
        prevAppAddr = aAddr;
        @(posedge clk);
        #1;
    endtask

    task automatic idleTick();
        logic junkRd, junkWr, aRd;
        junkRd = ($urandom_range(0, 9) == 0);
        junkWr = ($urandom_range(0, 9) == 0);
        aRd    = appRandom && ($urandom_range(0, 1) == 1);
        applyStimulus(junkRd, junkWr, 1'b0, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                      $urandom, aRd, int'($urandom_range(0, 63)));
    endtask

    task automatic waitAck();
        int  n = 0;
        bit  seenHigh = 1'b0;
        while (n < 200 && !(seenHigh && !mem_ack)) begin
            if (mem_ack) seenHigh = 1'b1;
            idleTick();
            n++;
        end
        if (!(seenHigh && !mem_ack)) begin
            tests++;
            fails++;
            $display("[TB] FAIL ack_timeout: got no mem_ack pulse expected one within 200 clks");
        end
    endtask

    task automatic pioOp(input logic isWr, input int entry, input int word, input logic [31:0] din);
        logic aRd;
        aRd = appRandom && ($urandom_range(0, 1) == 1);
        applyStimulus(!isWr, isWr, 1'b1, entry, word, din, aRd, int'($urandom_range(0, 63)));
        waitAck();
    endtask

    task automatic resetModel();
        appQ.delete();
        pioQ.delete();
        wrQ.delete();
        stageM[0] = '0;
        stageM[1] = '0;
        snapM     = '0;
        curRdata  = '0;
        prevAppRd = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_active"}, {77'b0, wr_active}, 78'b0);
        checkOutput({tag, "_wr_addr"}, {72'b0, wr_addr}, 78'b0);
        checkOutput({tag, "_wr_data"}, {6'b0, wr_data}, 78'b0);
        checkOutput({tag, "_mem_ack"}, {77'b0, mem_ack}, 78'b0);
        checkOutput({tag, "_mem_rdata"}, {46'b0, mem_rdata}, 78'b0);
        checkOutput({tag, "_app_ack"}, {77'b0, app_mem_ack}, 78'b0);
        checkOutput({tag, "_app_rdata"}, {6'b0, app_mem_rdata}, 78'b0);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 90000 clks");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ackCnt;
        int ackHigh;
        rst_n = 1'b0;
        reg_rd = 0; reg_wr = 0; reg_ms = 0; reg_addr = 0; reg_din = 0;
        app_mem_rd = 0; app_mem_raddr = 0;
        appRandom = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;
        repeat (2) idleTick();

        // Populate every entry so all later reads have defined rows
        for (int e = 0; e < 64; e++)
            for (int w = 0; w < 3; w++) pioOp(1'b1, e, w, $urandom);

        // Directed commit and coherent readback of entry 5
        pioOp(1'b1, 5, 0, 32'h11111111);
        pioOp(1'b1, 5, 1, 32'h22222222);
        pioOp(1'b1, 5, 2, 32'h000000FF);
        pioOp(1'b0, 5, 0, 32'h0);
        pioOp(1'b0, 5, 1, 32'h0);
        pioOp(1'b0, 5, 2, 32'h0);
        checkOutput("entry5_w2_direct", {46'b0, mem_rdata}, {46'b0, 32'h000000FF});

        // Hole word: acked, no commit, reads zero
        pioOp(1'b1, 4, 3, 32'hDEADBEEF);
        pioOp(1'b0, 4, 3, 32'h0);
        checkOutput("hole_read_direct", {46'b0, mem_rdata}, 78'b0);

        // App burst of six with a colliding PIO word-0 read at clk 2
        ackCnt  = 0;
        ackHigh = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i == 2, 1'b0, 1'b1, 3, 0, 32'h0, 1'b1, i);
            if (i >= 1 && app_mem_ack) ackCnt++;
            if (mem_ack) ackHigh++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 0);
        if (app_mem_ack) ackCnt++;
        if (mem_ack) ackHigh++;
        checkOutput("burst_ack_count", 78'(ackCnt), 78'd6);
        checkOutput("burst_no_early_ack", 78'(ackHigh), 78'd0);
        waitAck();

        // Commit to entry 7 in the clk its app read uses the RAM, then read again
        pioOp(1'b1, 7, 0, 32'hA5A5A5A5);
        pioOp(1'b1, 7, 1, 32'h5A5A5A5A);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 7);
        applyStimulus(1'b0, 1'b1, 1'b1, 7, 2, 32'h0000003C, 1'b1, 7);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 0);
        waitAck();

        // Randomized mix of PIO ops with background app traffic
        appRandom = 1'b1;
        for (int n = 0; n < 250; n++) begin
            pioOp(logic'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 3)), $urandom);
        end

        // Reset while a PIO read is pending behind app traffic
        appRandom = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 1'b1, 12, 0, 32'h0, 1'b1, 11);
        rst_n = 1'b0;
        resetModel();
        #1;
        checkAllZero("midop_reset");
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 0);
        rst_n = 1'b1;
        ackHigh = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 0);
            if (mem_ack) ackHigh++;
        end
        checkOutput("no_ack_after_reset", 78'(ackHigh), 78'd0);
        pioOp(1'b0, 0, 1, 32'h0);
        checkOutput("snap_cleared", {46'b0, mem_rdata}, 78'b0);
        pioOp(1'b1, 9, 2, 32'h000000AB);
        pioOp(1'b0, 9, 0, 32'h0);
        pioOp(1'b0, 9, 1, 32'h0);
        pioOp(1'b0, 9, 2, 32'h0);

        // Drain and confirm nothing expected was left unseen
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 0);
        checkOutput("app_queue_drained", 78'(appQ.size()), 78'd0);
        checkOutput("pio_queue_drained", 78'(pioQ.size()), 78'd0);
        checkOutput("wr_queue_drained", 78'(wrQ.size()), 78'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
